bus_tracer: RTL and testbench

Passive observer on the 4-bit system bus, between the CPU/ROM/RAM bus and the debug/host side. Follows the 8-clock instruction cycle from `sync`. For each instruction cycle it builds a record of the 12-bit fetch address, the 8-bit opcode and the X2 data nibble. Records are buffered in a FIFO and drained over a valid/ready interface. It never drives the bus.

---
 rtl/bus_tracer.sv | 133 +++++++++++++
 tb/tb_bus_tracer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_tracer.sv
// bus_tracer: passive 4-bit bus observer. It follows the 8-clock instruction
// cycle from sync and assembles {addr, opcode, x2} records. Records go into a
// small FIFO that is drained over a valid/ready interface.
module bus_tracer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  data,
    input  logic        sync,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [23:0] rec_data,
    output logic        locked,
    output logic        sync_err,
    output logic        overflow,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  opcode;
        logic [3:0]  x2;
    } rec_t;

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    phase_t      p;
    logic        armed;      // previous cycle boundary was a clean X3, so this cycle is whole
    logic [11:0] addr_q;
    logic [7:0]  opcode_q;

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic        full, empty;
    logic        push_req, do_push, do_pop, drop;
    rec_t        new_rec;

    // Phase tracker and field capture; faults discard the partial record by disarming.
    always_ff @(posedge clock) begin
        if (reset) begin
            p        <= A1;
            locked   <= 1'b0;
            armed    <= 1'b0;
            sync_err <= 1'b0;
            addr_q   <= '0;
            opcode_q <= '0;
        end else begin
            sync_err <= 1'b0;
            if (locked) begin
                case (p)
                    A1:      addr_q[3:0]   <= data;
                    A2:      addr_q[7:4]   <= data;
                    A3:      addr_q[11:8]  <= data;
                    M1:      opcode_q[7:4] <= data;
                    M2:      opcode_q[3:0] <= data;
                    default: ;
                endcase
            end
            if (!locked) begin
                if (sync) begin
                    locked <= 1'b1;
                    p      <= A1;
                    armed  <= 1'b0;
                end
            end else if (p == X3) begin
                p <= A1;
                if (sync) begin
                    armed <= 1'b1;
                end else begin
                    locked   <= 1'b0;
                    sync_err <= 1'b1;
                    armed    <= 1'b0;
                end
            end else if (sync) begin
                p        <= A1;
                sync_err <= 1'b1;
                armed    <= 1'b0;
            end else begin
                p <= phase_t'(p + 3'd1);
            end
        end
    end

    // Push/pop decisions; a pop frees the slot a same-clock push into a full FIFO needs.
    always_comb begin
        new_rec   = '{addr: addr_q, opcode: opcode_q, x2: data};
        push_req  = enable && locked && armed && (p == X2) && !sync;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rec_valid = !empty;
        do_pop    = rec_valid && rec_ready;
        do_push   = push_req && (!full || do_pop);
        drop      = push_req && full && !do_pop;
        wr_nxt    = wr_ptr + (AW+1)'(do_push);
        rd_nxt    = rd_ptr + (AW+1)'(do_pop);
    end

    // Record storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    // Pointers, registered head record and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rec_data   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
            // Head is the incoming record when the FIFO is (or just became) empty.
            if (wr_nxt != rd_nxt) begin
                if (do_push && (rd_nxt == wr_ptr))
                    rec_data <= new_rec;
                else
                    rec_data <= mem[rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_bus_tracer.sv
// Bench for bus_tracer: scenario tasks drive bus cycles, push expected
// records to a queue, and compare the FIFO head on every accepted pop.
module tb_bus_tracer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  data = 4'h0;
    logic        sync = 1'b0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    logic [23:0] rec_data;
    logic        locked;
    logic        sync_err;
    logic        overflow;
    logic [7:0]  drop_count;

    int          checks = 0;
    int          errors = 0;
    int          serr_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_rec;

    bus_tracer #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .data(data), .sync(sync),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .locked(locked), .sync_err(sync_err), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    // One clock: drive bus, score any pop the DUT takes at this edge, then settle.
    task automatic step(input logic s, input logic [3:0] d);
        sync = s;
        data = d;
        if (!reset && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_extra: rec_data=%h, no record expected", rec_data);
            end else begin
                exp_rec = exp_q.pop_front();
                if (rec_data !== exp_rec) begin
                    errors++;
                    $display("FAIL pop_order: rec_data=%h expected %h", rec_data, exp_rec);
                end
            end
        end
        @(posedge clock);
        #1;
        if (sync_err) serr_cnt++;
    endtask

    // Full instruction cycle A1..X3; end_sync is the sync value on X3.
    task automatic run_cycle(input logic [11:0] a, input logic [7:0] o, input logic [3:0] x,
                             input logic end_sync, input logic exp_push);
        step(1'b0, a[3:0]);
        step(1'b0, a[7:4]);
        step(1'b0, a[11:8]);
        step(1'b0, o[7:4]);
        step(1'b0, o[3:0]);
        step(1'b0, 4'h0);
        if (exp_push) exp_q.push_back({a, o, x});
        step(1'b0, x);
        step(end_sync, 4'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step(1'b0, 4'h0);
        reset = 1'b0;
        checks++;
        if ({rec_valid, locked, sync_err, overflow, drop_count, rec_data} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rec_valid, locked, sync_err, overflow, drop_count, rec_data});
        end
        repeat (20) step(1'b0, 4'($urandom_range(15)));
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked: got %b expected 0", locked); end
        checks++;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", rec_valid); end
        checks++;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL idle_drops: got %0d expected 0", drop_count); end
    endtask

    task automatic test_lock_capture();
        step(1'b1, 4'h0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", locked); end
        run_cycle(12'h234, 8'hD5, 4'h9, 1'b1, 1'b0);
        checks++;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL first_partial: rec_valid=%b expected 0", rec_valid); end
        step(1'b0, 4'h4); step(1'b0, 4'h3); step(1'b0, 4'h2);
        step(1'b0, 4'hD); step(1'b0, 4'h5); step(1'b0, 4'h0);
        checks++;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL pre_x2_valid: got %b expected 0", rec_valid); end
        exp_q.push_back(24'h234D59);
        step(1'b0, 4'h9);
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== 24'h234D59) begin
            errors++;
            $display("FAIL x2_latency: valid=%b data=%h expected 1 234d59", rec_valid, rec_data);
        end
        step(1'b1, 4'h0);
        checks++;
        if (rec_data !== 24'h234D59) begin errors++; $display("FAIL head_stable: got %h expected 234d59", rec_data); end
    endtask

    task automatic test_enable();
        rec_ready = 1'b1;
        enable = 1'b0;
        run_cycle(12'hF0F, 8'h77, 4'h1, 1'b1, 1'b0);
        checks++;
        if (rec_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL enable_off: valid=%b pending=%0d expected 0 0", rec_valid, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        rec_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++)
            run_cycle(12'h100 + 12'(i), 8'hA0 + 8'(i), 4'(i), 1'b1, i < 8);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++;
        if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops: got %0d expected 2", drop_count); end
        rec_ready = 1'b1;
        enable = 1'b0;
        repeat (2) run_cycle(12'h000, 8'h00, 4'h0, 1'b1, 1'b0);
        checks++;
        if (rec_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain: valid=%b pending=%0d expected 0 0", rec_valid, exp_q.size());
        end
    endtask

    task automatic test_full_pushpop();
        rec_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++)
            run_cycle(12'h800 + 12'(i), 8'h50 + 8'(i), 4'(15 - i), 1'b1, 1'b1);
        step(1'b0, 4'h1); step(1'b0, 4'h2); step(1'b0, 4'h3);
        step(1'b0, 4'h4); step(1'b0, 4'h5); step(1'b0, 4'h0);
        rec_ready = 1'b1;
        exp_q.push_back(24'h321456);
        step(1'b0, 4'h6);
        rec_ready = 1'b0;
        step(1'b1, 4'h0);
        checks++;
        if (drop_count !== 8'd2) begin errors++; $display("FAIL pushpop_drops: got %0d expected 2", drop_count); end
        run_cycle(12'hEEE, 8'hEE, 4'hE, 1'b1, 1'b0);
        checks++;
        if (drop_count !== 8'd3) begin errors++; $display("FAIL still_full: drops=%0d expected 3", drop_count); end
        rec_ready = 1'b1;
        enable = 1'b0;
        repeat (2) run_cycle(12'h000, 8'h00, 4'h0, 1'b1, 1'b0);
        checks++;
        if (rec_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pushpop_drain: valid=%b pending=%0d expected 0 0", rec_valid, exp_q.size());
        end
    endtask

    task automatic test_resync();
        int s0;
        rec_ready = 1'b1;
        enable = 1'b1;
        s0 = serr_cnt;
        step(1'b0, 4'h1); step(1'b0, 4'h2); step(1'b0, 4'h3);
        step(1'b1, 4'h4);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL resync_pulse: sync_err=%b locked=%b expected 1 1", sync_err, locked);
        end
        enable = 1'b0;
        run_cycle(12'h5A5, 8'h3C, 4'hE, 1'b1, 1'b0);
        checks++;
        if (serr_cnt - s0 != 1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL resync_width: pulses=%0d locked=%b expected 1 1", serr_cnt - s0, locked);
        end
        enable = 1'b1;
        run_cycle(12'hABC, 8'h12, 4'h7, 1'b1, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL resync_capture: pending=%0d expected 0", exp_q.size()); end
    endtask

    task automatic test_missing_sync();
        int s0;
        rec_ready = 1'b1;
        enable = 1'b1;
        s0 = serr_cnt;
        run_cycle(12'h111, 8'h22, 4'h3, 1'b0, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL miss_pulse: sync_err=%b locked=%b expected 1 0", sync_err, locked);
        end
        repeat (3) step(1'b0, 4'h0);
        checks++;
        if (serr_cnt - s0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL miss_unlocked: pulses=%0d locked=%b expected 1 0", serr_cnt - s0, locked);
        end
        step(1'b1, 4'h0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", locked); end
        run_cycle(12'h777, 8'h88, 4'h9, 1'b1, 1'b0);
        run_cycle(12'hFED, 8'hCB, 4'hA, 1'b1, 1'b1);
        checks++;
        if (rec_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL relock_push: valid=%b pending=%0d expected 0 0", rec_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rec_ready = 1'b0;
        enable = 1'b1;
        run_cycle(12'h321, 8'h54, 4'h6, 1'b1, 1'b1);
        step(1'b0, 4'h1); step(1'b0, 4'h2);
        reset = 1'b1;
        step(1'b0, 4'h3);
        checks++;
        if ({rec_valid, locked, sync_err, overflow, drop_count, rec_data} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0",
                     {rec_valid, locked, sync_err, overflow, drop_count, rec_data});
        end
        exp_q.delete();
        reset = 1'b0;
        step(1'b0, 4'h4);
        checks++;
        if (locked !== 1'b0 || rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: locked=%b valid=%b expected 0 0", locked, rec_valid);
        end
    endtask

    initial begin
        test_reset();
        test_lock_capture();
        test_enable();
        test_overflow();
        test_full_pushpop();
        test_resync();
        test_missing_sync();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
